// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - parity modes, tx state encoding and width helper shared by the UART blocks
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // Never returns less than 1 so a counter for a count of 1 still has a bit.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - bit-period counter; bit_end marks the last clk of each bit period
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic areset_n,
    input  logic clear,
    input  logic run,
    output logic bit_end
);

    localparam int                CNT_W = clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;

    assign bit_end = run && (r_cnt == LAST);

    // Held at zero while stopped so the first bit after a start is full length.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_cnt <= '0;
        end else if (clear || !run || bit_end) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - configurable UART transmitter with valid/ready intake and sync abort
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 areset_n,
    input  logic                 clr,
    input  logic [DATA_BITS-1:0] s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int               BIT_W     = clog2(DATA_BITS);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    tx_state_t            r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_parity;
    logic [BIT_W-1:0]     r_bit_cnt;
    logic                 r_stop_cnt;
    logic                 r_tx;
    logic                 r_busy;
    logic                 r_done;

    logic w_accept;
    logic w_bit_end;
    logic w_run;

    assign s_ready  = (r_state == ST_IDLE) && !clr;
    assign w_accept = s_valid && s_ready;
    assign w_run    = (r_state != ST_IDLE);

    assign tx   = r_tx;
    assign busy = r_busy;
    assign done = r_done;

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk     (clk),
        .areset_n(areset_n),
        .clear   (clr || w_accept),
        .run     (w_run),
        .bit_end (w_bit_end)
    );

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else if (clr) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_shift    <= s_data;
                        r_parity   <= (PARITY == PAR_ODD) ? ~^s_data : ^s_data;
                        r_bit_cnt  <= '0;
                        r_stop_cnt <= 1'b0;
                        r_tx       <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_bit_end) begin
                        r_tx      <= r_shift[0];
                        r_bit_cnt <= '0;
                        r_state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        // r_shift[1] is the bit that becomes the LSB after this shift.
                        if (r_bit_cnt != LAST_BIT) begin
                            r_shift   <= r_shift >> 1;
                            r_tx      <= r_shift[1];
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end else if (PARITY != PAR_NONE) begin
                            r_tx    <= r_parity;
                            r_state <= ST_PARITY;
                        end else begin
                            r_tx       <= 1'b1;
                            r_stop_cnt <= 1'b0;
                            r_state    <= ST_STOP;
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_bit_end) begin
                        r_tx       <= 1'b1;
                        r_stop_cnt <= 1'b0;
                        r_state    <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (w_bit_end) begin
                        if (r_stop_cnt != LAST_STOP) begin
                            r_stop_cnt <= 1'b1;
                        end else begin
                            r_stop_cnt <= 1'b0;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_state    <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - self-checking bench for uart_tx_cfg over several frame formats
module tb_uart_tx_cfg;

    localparam int N = 5;

    logic         clk = 1'b0;
    logic         areset_n;
    logic         clr;
    logic [8:0]   s_data [N];
    logic [N-1:0] s_valid;
    logic [N-1:0] s_ready;
    logic [N-1:0] tx;
    logic [N-1:0] busy;
    logic [N-1:0] done;

    int n_checks = 0;
    int n_errors = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    // 0: 8N1, 1: 8E1, 2: 8O1, 3: 7N2 (all 4 clk/bit), 4: 8N1 at 868 clk/bit
    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .areset_n(areset_n), .clr(clr), .s_data(s_data[0][7:0]), .s_valid(s_valid[0]),
        .s_ready(s_ready[0]), .tx(tx[0]), .busy(busy[0]), .done(done[0]));
    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .areset_n(areset_n), .clr(clr), .s_data(s_data[1][7:0]), .s_valid(s_valid[1]),
        .s_ready(s_ready[1]), .tx(tx[1]), .busy(busy[1]), .done(done[1]));
    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .areset_n(areset_n), .clr(clr), .s_data(s_data[2][7:0]), .s_valid(s_valid[2]),
        .s_ready(s_ready[2]), .tx(tx[2]), .busy(busy[2]), .done(done[2]));
    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
        .clk(clk), .areset_n(areset_n), .clr(clr), .s_data(s_data[3][6:0]), .s_valid(s_valid[3]),
        .s_ready(s_ready[3]), .tx(tx[3]), .busy(busy[3]), .done(done[3]));
    uart_tx_cfg #(.CLKS_PER_BIT(868), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_slow (
        .clk(clk), .areset_n(areset_n), .clr(clr), .s_data(s_data[4][7:0]), .s_valid(s_valid[4]),
        .s_ready(s_ready[4]), .tx(tx[4]), .busy(busy[4]), .done(done[4]));

    function automatic int cfg_cpb(input int i);
        return (i == 4) ? 868 : 4;
    endfunction
    function automatic int cfg_db(input int i);
        return (i == 3) ? 7 : 8;
    endfunction
    function automatic int cfg_par(input int i);
        return (i == 1) ? 2 : ((i == 2) ? 1 : 0);
    endfunction
    function automatic int cfg_sb(input int i);
        return (i == 3) ? 2 : 1;
    endfunction

    function automatic int frame_len(input int i);
        return 1 + cfg_db(i) + ((cfg_par(i) != 0) ? 1 : 0) + cfg_sb(i);
    endfunction

    // Line level of every bit of the frame, index 0 = start bit.
    function automatic logic [15:0] frame_bits(input int i, input logic [8:0] d);
        logic [15:0] b;
        int ones;
        int n;
        b = '0;
        ones = 0;
        n = 1;
        for (int j = 0; j < cfg_db(i); j++) begin
            b[n] = d[j];
            if (d[j]) ones++;
            n++;
        end
        if (cfg_par(i) == 2) begin
            b[n] = ((ones % 2) == 1);
            n++;
        end else if (cfg_par(i) == 1) begin
            b[n] = ((ones % 2) == 0);
            n++;
        end
        for (int j = 0; j < cfg_sb(i); j++) begin
            b[n] = 1'b1;
            n++;
        end
        return b;
    endfunction

    // Reference: m_k = clocks since acceptance, -1 when no frame is on the line.
    int          m_k    [N];
    int          m_len  [N];
    logic [15:0] m_bits [N];
    logic        m_done [N];

    always @(posedge clk or negedge areset_n) begin
        for (int i = 0; i < N; i++) begin
            if (!areset_n || clr) begin
                m_k[i]    <= -1;
                m_done[i] <= 1'b0;
            end else if (m_k[i] < 0) begin
                m_done[i] <= 1'b0;
                if (s_valid[i]) begin
                    m_bits[i] <= frame_bits(i, s_data[i]);
                    m_len[i]  <= frame_len(i);
                    m_k[i]    <= 0;
                end
            end else if (m_k[i] + 1 == m_len[i] * cfg_cpb(i)) begin
                m_k[i]    <= -1;
                m_done[i] <= 1'b1;
            end else begin
                m_k[i]    <= m_k[i] + 1;
                m_done[i] <= 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < N; i++) begin
                logic e_tx;
                e_tx = (m_k[i] < 0) ? 1'b1 : m_bits[i][m_k[i] / cfg_cpb(i)];
                check($sformatf("model_tx[%0d]", i), 32'(tx[i]), 32'(e_tx));
                check($sformatf("model_busy[%0d]", i), 32'(busy[i]), 32'(m_k[i] >= 0));
                check($sformatf("model_done[%0d]", i), 32'(done[i]), 32'(m_done[i]));
                check($sformatf("model_ready[%0d]", i), 32'(s_ready[i]), 32'((m_k[i] < 0) && !clr));
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ready(input int i);
        int n;
        n = 0;
        while (!s_ready[i] && n < 10000) begin
            step();
            n++;
        end
        check($sformatf("wait_ready[%0d]", i), 32'(s_ready[i]), 32'd1);
    endtask

    typedef struct {
        int          inst;
        logic [8:0]  data;
        logic [15:0] bits;
        int          len;
    } vec_t;

    vec_t vecs [8];

    task automatic run_vec(input vec_t v);
        int first_done;
        int busy_cycles;
        wait_ready(v.inst);
        s_valid[v.inst] = 1'b1;
        s_data[v.inst]  = v.data;
        step();
        s_valid[v.inst] = 1'b0;
        s_data[v.inst]  = ~v.data;
        first_done  = -1;
        busy_cycles = 0;
        for (int c = 0; c < v.len * 4 + 3; c++) begin
            if (c > 0) step();
            if ((c % 4) == 2 && (c / 4) < v.len)
                check($sformatf("vec%0d_bit%0d", v.inst, c / 4), 32'(tx[v.inst]), 32'(v.bits[c / 4]));
            if (busy[v.inst]) busy_cycles++;
            if (done[v.inst] && first_done < 0) first_done = c;
        end
        check($sformatf("vec%0d_done_at", v.inst), 32'(first_done), 32'(v.len * 4));
        check($sformatf("vec%0d_busy_len", v.inst), 32'(busy_cycles), 32'(v.len * 4));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_done;
        int nd;
        int low;
        int c;

        vecs[0] = '{inst: 0, data: 9'h0A5, bits: 16'h034A, len: 10};
        vecs[1] = '{inst: 1, data: 9'h0A5, bits: 16'h054A, len: 11};
        vecs[2] = '{inst: 2, data: 9'h0A5, bits: 16'h074A, len: 11};
        vecs[3] = '{inst: 3, data: 9'h07F, bits: 16'h03FE, len: 10};
        vecs[4] = '{inst: 0, data: 9'h000, bits: 16'h0200, len: 10};
        vecs[5] = '{inst: 1, data: 9'h001, bits: 16'h0602, len: 11};
        vecs[6] = '{inst: 2, data: 9'h003, bits: 16'h0606, len: 11};
        vecs[7] = '{inst: 3, data: 9'h055, bits: 16'h03AA, len: 10};

        areset_n = 1'b0;
        clr      = 1'b0;
        s_valid  = '0;
        for (int i = 0; i < N; i++) s_data[i] = '0;
        repeat (3) step();
        check("reset_tx", 32'(tx), 32'h1F);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        check("reset_ready", 32'(s_ready), 32'h1F);
        areset_n = 1'b1;
        chk_en   = 1'b1;
        step();

        for (int v = 0; v < 8; v++) run_vec(vecs[v]);

        // Back-to-back: s_valid held, new start bit on the edge right after done
        wait_ready(0);
        s_valid[0] = 1'b1;
        s_data[0]  = 9'h055;
        step();
        s_data[0]  = 9'h0AA;
        first_done = -1;
        for (int k = 1; k <= 60 && first_done < 0; k++) begin
            step();
            if (done[0]) first_done = k;
        end
        check("b2b_done_at", 32'(first_done), 32'd40);
        step();
        s_valid[0] = 1'b0;
        s_data[0]  = 9'h133;
        check("b2b_start_tx", 32'(tx[0]), 32'd0);
        check("b2b_start_busy", 32'(busy[0]), 32'd1);
        wait_ready(0);

        // Abort mid-frame; clr also blocks a simultaneous accept on another channel
        wait_ready(1);
        s_valid[0] = 1'b1;
        s_data[0]  = 9'h0C3;
        step();
        s_valid[0] = 1'b0;
        repeat (13) step();
        clr        = 1'b1;
        s_valid[1] = 1'b1;
        s_data[1]  = 9'h1FF;
        #1;
        check("clr_ready_gate", 32'(s_ready[1]), 32'd0);
        step();
        check("clr_tx", 32'(tx[0]), 32'd1);
        check("clr_busy", 32'(busy[0]), 32'd0);
        check("clr_beats_accept", 32'(busy[1]), 32'd0);
        clr        = 1'b0;
        s_valid[1] = 1'b0;
        #1;
        check("clr_ready", 32'(s_ready[0]), 32'd1);
        nd = 0;
        repeat (60) begin
            step();
            if (done[0] || done[1]) nd++;
        end
        check("clr_no_done", 32'(nd), 32'd0);
        run_vec(vecs[0]);

        // Asynchronous reset in the middle of a data bit
        wait_ready(0);
        s_valid[0] = 1'b1;
        s_data[0]  = 9'h00F;
        step();
        s_valid[0] = 1'b0;
        repeat (14) step();
        #1 areset_n = 1'b0;
        #1;
        check("arst_tx", 32'(tx[0]), 32'd1);
        check("arst_busy", 32'(busy[0]), 32'd0);
        check("arst_done", 32'(done[0]), 32'd0);
        check("arst_ready", 32'(s_ready[0]), 32'd1);
        step();
        areset_n = 1'b1;
        step();
        run_vec(vecs[1]);

        // Randomised traffic on the fast channels, occasional clr
        for (int n = 0; n < 3000; n++) begin
            step();
            for (int i = 0; i < 4; i++) begin
                s_valid[i] = ($urandom_range(3) != 0);
                s_data[i]  = 9'($urandom);
            end
            clr = ($urandom_range(199) == 0);
        end
        clr     = 1'b0;
        s_valid = '0;
        for (int i = 0; i < 4; i++) wait_ready(i);

        // Full-rate bit period
        wait_ready(4);
        s_valid[4] = 1'b1;
        s_data[4]  = 9'h0A5;
        step();
        s_valid[4] = 1'b0;
        low = 0;
        while (tx[4] == 1'b0 && low < 2000) begin
            low++;
            step();
        end
        check("cpb868_start_width", 32'(low), 32'd868);
        c = low;
        while (!done[4] && c < 10000) begin
            step();
            c++;
        end
        check("cpb868_done_at", 32'(c), 32'd8680);
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
